// File: rtl/nabp_filtered_ram_server_pkg.sv
// Shared widths and bank-state encoding for the filtered-RAM angle server.
package nabp_filtered_ram_server_pkg;
    localparam int kFilteredDataLength = 12;
    localparam int kSLength            = 9;
    localparam int kAngleLength        = 9;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_READY   = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;
endpackage

// File: rtl/nabp_filtered_ram_bank.sv
// One projection bank: single write port, two independent registered read ports.
module nabp_filtered_ram_bank #(
    parameter int pFilteredDataLength = 12,
    parameter int pSLength            = 9
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [pSLength-1:0]            wr_addr,
    input  logic [pFilteredDataLength-1:0] wr_val,
    input  logic [pSLength-1:0]            rd0_addr,
    input  logic [pSLength-1:0]            rd1_addr,
    output logic [pFilteredDataLength-1:0] rd0_val,
    output logic [pFilteredDataLength-1:0] rd1_val
);
    logic [pFilteredDataLength-1:0] mem [0:(1<<pSLength)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_val;
        rd0_val <= mem[rd0_addr];
        rd1_val <= mem[rd1_addr];
    end
endmodule

// File: rtl/nabp_filtered_ram_server.sv
// Ping-pong filtered-sample store: filter fills one bank while back-projection
// reads the other; banks are handed to the reader through a next-angle handshake.
module nabp_filtered_ram_server
    import nabp_filtered_ram_server_pkg::*;
#(
    parameter int pFilteredDataLength = kFilteredDataLength,
    parameter int pSLength            = kSLength,
    parameter int pAngleLength        = kAngleLength
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           fl_ready,
    input  logic                           fl_wr_en,
    input  logic [pSLength-1:0]            fl_wr_addr,
    input  logic [pFilteredDataLength-1:0] fl_wr_val,
    input  logic                           fl_commit,
    input  logic [pAngleLength-1:0]        fl_angle,
    input  logic                           fl_last,
    input  logic                           fr_next_angle,
    output logic                           fr_next_angle_ack,
    output logic [pAngleLength-1:0]        fr_angle,
    output logic                           fr_has_next_angle,
    input  logic [pSLength-1:0]            fr0_s_val,
    input  logic [pSLength-1:0]            fr1_s_val,
    output logic [pFilteredDataLength-1:0] fr0_val,
    output logic [pFilteredDataLength-1:0] fr1_val
);
    bank_state_t             state_q [2];
    bank_state_t             state_d [2];
    logic [pAngleLength-1:0] bank_angle [2];
    logic [1:0]              bank_last;
    logic                    last_seen;

    logic fill_idx, fill_ok, rdy_idx, rdy_ok, rd_idx, rd_any;
    logic wr_go, commit_go, grant;
    logic [1:0] bank_wr;
    logic [1:0][pFilteredDataLength-1:0] bank_rd0, bank_rd1;

    always_comb begin
        fill_idx = 1'b0;
        fill_ok  = 1'b1;
        if (state_q[0] == BANK_FILLING)      fill_idx = 1'b0;
        else if (state_q[1] == BANK_FILLING) fill_idx = 1'b1;
        else if (state_q[0] == BANK_EMPTY)   fill_idx = 1'b0;
        else if (state_q[1] == BANK_EMPTY)   fill_idx = 1'b1;
        else                                 fill_ok  = 1'b0;

        // Two READY banks can only coexist before the first grant, and bank 0
        // is always the one filled first then, so the low index is the older.
        rdy_ok  = (state_q[0] == BANK_READY) || (state_q[1] == BANK_READY);
        rdy_idx = (state_q[0] != BANK_READY);
        rd_any  = (state_q[0] == BANK_READING) || (state_q[1] == BANK_READING);
        rd_idx  = (state_q[1] == BANK_READING);

        wr_go     = fl_wr_en && fill_ok;
        commit_go = fl_commit && fill_ok;
        // The ack cycle itself is never a new request.
        grant     = fr_next_angle && !fr_next_angle_ack && !last_seen && rdy_ok;
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (grant && state_q[b] == BANK_READING)
                state_d[b] = BANK_EMPTY;
        end
        if (grant)
            state_d[rdy_idx] = BANK_READING;
        if (commit_go)
            state_d[fill_idx] = BANK_READY;
        else if (wr_go && state_q[fill_idx] == BANK_EMPTY)
            state_d[fill_idx] = BANK_FILLING;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b]    <= BANK_EMPTY;
                bank_angle[b] <= '0;
            end
            bank_last         <= '0;
            last_seen         <= 1'b0;
            fr_next_angle_ack <= 1'b0;
            fr_angle          <= '0;
        end else begin
            for (int b = 0; b < 2; b++)
                state_q[b] <= state_d[b];
            if (commit_go) begin
                bank_angle[fill_idx] <= fl_angle;
                bank_last[fill_idx]  <= fl_last;
            end
            fr_next_angle_ack <= grant;
            if (grant) begin
                fr_angle <= bank_angle[rdy_idx];
                if (bank_last[rdy_idx])
                    last_seen <= 1'b1;
            end
        end
    end

    assign fl_ready          = fill_ok;
    assign fr_has_next_angle = !last_seen;
    assign bank_wr[0]        = wr_go && !fill_idx;
    assign bank_wr[1]        = wr_go && fill_idx;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        nabp_filtered_ram_bank #(
            .pFilteredDataLength(pFilteredDataLength),
            .pSLength           (pSLength)
        ) u_bank (
            .clk     (clk),
            .wr_en   (bank_wr[b]),
            .wr_addr (fl_wr_addr),
            .wr_val  (fl_wr_val),
            .rd0_addr(fr0_s_val),
            .rd1_addr(fr1_s_val),
            .rd0_val (bank_rd0[b]),
            .rd1_val (bank_rd1[b])
        );
    end

    // Both banks read every cycle; the READING index picks which one is seen.
    assign fr0_val = rd_any ? bank_rd0[rd_idx] : '0;
    assign fr1_val = rd_any ? bank_rd1[rd_idx] : '0;
endmodule

// File: tb/tb_nabp_filtered_ram_server.sv
// Directed bench for nabp_filtered_ram_server: handshake, ping-pong, last-angle and reset.
module tb_nabp_filtered_ram_server;
    localparam int DW  = 12;
    localparam int AW  = 9;
    localparam int ANW = 9;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           fl_ready;
    logic           fl_wr_en = 1'b0;
    logic [AW-1:0]  fl_wr_addr = '0;
    logic [DW-1:0]  fl_wr_val = '0;
    logic           fl_commit = 1'b0;
    logic [ANW-1:0] fl_angle = '0;
    logic           fl_last = 1'b0;
    logic           fr_next_angle = 1'b0;
    logic           fr_next_angle_ack;
    logic [ANW-1:0] fr_angle;
    logic           fr_has_next_angle;
    logic [AW-1:0]  fr0_s_val = '0;
    logic [AW-1:0]  fr1_s_val = '0;
    logic [DW-1:0]  fr0_val;
    logic [DW-1:0]  fr1_val;

    int n_chk = 0;
    int n_err = 0;

    nabp_filtered_ram_server #(
        .pFilteredDataLength(DW),
        .pSLength           (AW),
        .pAngleLength       (ANW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fl_ready         (fl_ready),
        .fl_wr_en         (fl_wr_en),
        .fl_wr_addr       (fl_wr_addr),
        .fl_wr_val        (fl_wr_val),
        .fl_commit        (fl_commit),
        .fl_angle         (fl_angle),
        .fl_last          (fl_last),
        .fr_next_angle    (fr_next_angle),
        .fr_next_angle_ack(fr_next_angle_ack),
        .fr_angle         (fr_angle),
        .fr_has_next_angle(fr_has_next_angle),
        .fr0_s_val        (fr0_s_val),
        .fr1_s_val        (fr1_s_val),
        .fr0_val          (fr0_val),
        .fr1_val          (fr1_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        fl_wr_en      = 1'b0;
        fl_commit     = 1'b0;
        fl_last       = 1'b0;
        fr_next_angle = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input int a, input int v);
        fl_wr_en   = 1'b1;
        fl_wr_addr = AW'(a);
        fl_wr_val  = DW'(v);
        tick();
        fl_wr_en   = 1'b0;
    endtask

    task automatic commit(input int ang, input logic last);
        fl_commit = 1'b1;
        fl_angle  = ANW'(ang);
        fl_last   = last;
        tick();
        fl_commit = 1'b0;
        fl_last   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int acks;

        // reset state
        do_reset();
        chk("rst_ack", 32'(fr_next_angle_ack), 0);
        chk("rst_angle", 32'(fr_angle), 0);
        chk("rst_has_next", 32'(fr_has_next_angle), 1);
        chk("rst_fl_ready", 32'(fl_ready), 1);
        chk("rst_fr0", 32'(fr0_val), 0);
        chk("rst_fr1", 32'(fr1_val), 0);

        // basic fill / grant / read
        for (int a = 0; a < 512; a++) wr(a, a);
        commit(5, 1'b0);
        chk("t1_fl_ready", 32'(fl_ready), 1);
        fr_next_angle = 1'b1;
        chk("t1_ack_pre", 32'(fr_next_angle_ack), 0);
        tick();
        chk("t1_ack", 32'(fr_next_angle_ack), 1);
        chk("t1_angle", 32'(fr_angle), 5);
        chk("t1_has_next", 32'(fr_has_next_angle), 1);
        fr_next_angle = 1'b0;
        fr0_s_val = 9'd17;
        fr1_s_val = 9'd17;
        tick();
        chk("t1_ack_pulse", 32'(fr_next_angle_ack), 0);
        chk("t1_fr0_17", 32'(fr0_val), 17);
        chk("t1_fr1_17", 32'(fr1_val), 17);
        fr0_s_val = 9'd300;
        fr1_s_val = 9'd4;
        tick();
        chk("t1_fr0_300", 32'(fr0_val), 300);
        chk("t1_fr1_4", 32'(fr1_val), 4);

        // stalled request served one cycle after the commit edge
        do_reset();
        fr_next_angle = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fr_next_angle_ack) acks++;
        end
        for (int a = 0; a < 4; a++) wr(a, 40 + a);
        chk("t2_no_ack_empty", 32'(acks), 0);
        commit(3, 1'b0);
        chk("t2_ack_at_commit", 32'(fr_next_angle_ack), 0);
        tick();
        chk("t2_ack", 32'(fr_next_angle_ack), 1);
        chk("t2_angle", 32'(fr_angle), 3);
        fr_next_angle = 1'b0;
        fr0_s_val = 9'd2;
        fr1_s_val = 9'd3;
        tick();
        chk("t2_fr0", 32'(fr0_val), 42);
        chk("t2_fr1", 32'(fr1_val), 43);

        // ping-pong, ignored commit while full
        do_reset();
        for (int a = 0; a < 4; a++) wr(a, 100 + a);
        commit(0, 1'b0);
        for (int a = 0; a < 4; a++) wr(a, 200 + a);
        commit(1, 1'b0);
        chk("t3_full", 32'(fl_ready), 0);
        fl_wr_en   = 1'b1;
        fl_wr_addr = 9'd0;
        fl_wr_val  = 12'd999;
        commit(9, 1'b0);
        fl_wr_en = 1'b0;
        fr_next_angle = 1'b1;
        tick();
        chk("t3_ack0", 32'(fr_next_angle_ack), 1);
        chk("t3_angle0", 32'(fr_angle), 0);
        chk("t3_full_after_ack0", 32'(fl_ready), 0);
        fr_next_angle = 1'b0;
        fr0_s_val = 9'd1;
        fr1_s_val = 9'd3;
        tick();
        chk("t3_b0_fr0", 32'(fr0_val), 101);
        chk("t3_b0_fr1", 32'(fr1_val), 103);
        tick();
        chk("t3_b0_hold", 32'(fr0_val), 101);
        fr_next_angle = 1'b1;
        tick();
        chk("t3_ack1", 32'(fr_next_angle_ack), 1);
        chk("t3_angle1", 32'(fr_angle), 1);
        chk("t3_ready_after_ack1", 32'(fl_ready), 1);
        fr_next_angle = 1'b0;
        fr0_s_val = 9'd1;
        fr1_s_val = 9'd0;
        tick();
        chk("t3_b1_fr0", 32'(fr0_val), 201);
        chk("t3_b1_fr1", 32'(fr1_val), 200);

        // last angle blocks further grants
        do_reset();
        commit(179, 1'b1);
        chk("t4_has_next_pre", 32'(fr_has_next_angle), 1);
        fr_next_angle = 1'b1;
        tick();
        chk("t4_ack", 32'(fr_next_angle_ack), 1);
        chk("t4_angle", 32'(fr_angle), 179);
        chk("t4_has_next", 32'(fr_has_next_angle), 0);
        fr_next_angle = 1'b0;
        commit(180, 1'b0);
        fr_next_angle = 1'b1;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fr_next_angle_ack) acks++;
        end
        chk("t4_no_ack", 32'(acks), 0);
        chk("t4_angle_hold", 32'(fr_angle), 179);
        chk("t4_full", 32'(fl_ready), 0);
        #1 reset = 1'b1;
        #1;
        chk("t4_rst_has_next", 32'(fr_has_next_angle), 1);
        chk("t4_rst_fl_ready", 32'(fl_ready), 1);
        chk("t4_rst_angle", 32'(fr_angle), 0);
        idle_in();
        tick();
        reset = 1'b0;

        // asynchronous reset mid-fill and mid-read
        wr(0, 55);
        commit(7, 1'b0);
        fr_next_angle = 1'b1;
        tick();
        chk("t5_ack", 32'(fr_next_angle_ack), 1);
        fr_next_angle = 1'b0;
        fr0_s_val  = 9'd0;
        fr1_s_val  = 9'd0;
        fl_wr_en   = 1'b1;
        fl_wr_addr = 9'd0;
        fl_wr_val  = 12'd66;
        tick();
        chk("t5_fr0_pre", 32'(fr0_val), 55);
        chk("t5_fr1_pre", 32'(fr1_val), 55);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_ack", 32'(fr_next_angle_ack), 0);
        chk("t5_rst_angle", 32'(fr_angle), 0);
        chk("t5_rst_fr0", 32'(fr0_val), 0);
        chk("t5_rst_fr1", 32'(fr1_val), 0);
        chk("t5_rst_fl_ready", 32'(fl_ready), 1);
        chk("t5_rst_has_next", 32'(fr_has_next_angle), 1);
        idle_in();
        tick();
        reset = 1'b0;
        tick();
        chk("t5_post_fr0", 32'(fr0_val), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
